// File: rtl/sprite_line_if.sv
// sprite_line_if: timing, sprite parameters, ROM port and shifter strobes around sprite_line_ctrl
interface sprite_line_if #(
    parameter int ADDR_W = 9
);
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              line_start;
    logic              visible;
    logic [9:0]        sprite_x;
    logic [9:0]        sprite_y;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic [31:0]       sh_data;
    logic              sh_ld;
    logic              sh_en;
    logic              pix_valid;
    logic              busy;

    modport master (
        input  hcount, vcount, line_start, visible, sprite_x, sprite_y, base_addr, rom_data,
        output rom_addr, sh_data, sh_ld, sh_en, pix_valid, busy
    );

    modport slave (
        output hcount, vcount, line_start, visible, sprite_x, sprite_y, base_addr, rom_data,
        input  rom_addr, sh_data, sh_ld, sh_en, pix_valid, busy
    );
endinterface

// File: rtl/sprite_line_ctrl.sv
// sprite_line_ctrl: per-scanline fetch/load/shift sequencer for one 16-pixel 2bpp sprite row
module sprite_line_ctrl #(
    parameter int SPRITE_H = 16,
    parameter int PIX_CLKS = 2,
    parameter int ADDR_W   = 9
) (
    input logic clk,
    input logic reset,
    sprite_line_if.master bus
);
    localparam int PW = PIX_CLKS > 1 ? $clog2(PIX_CLKS) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(PIX_CLKS - 1);
    localparam logic [PW-1:0] PH_TAIL = PW'(PIX_CLKS > 1 ? PIX_CLKS - 2 : 0);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ARMED, SHIFT} state_t;

    state_t            state, state_nx;
    logic [9:0]        x_lat, row;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        pcnt;
    logic [PW-1:0]     ph;
    logic              pix_valid, hit, match, wrap, done, sh_ld, sh_en;

    // row wraps when vcount < sprite_y, so the single compare also rejects lines above the sprite
    assign row   = bus.vcount - bus.sprite_y;
    assign hit   = bus.visible && row < 10'(SPRITE_H);
    assign match = bus.hcount == 11'(32'(x_lat) * PIX_CLKS);
    assign wrap  = ph == PH_LAST;
    // pulse 1 comes from ARMED, so pcnt reaches 15 on the 16th pulse; then PIX_CLKS-1 tail cycles
    assign done  = PIX_CLKS == 1 ? pcnt == 4'd14 : pcnt == 4'd15 && ph == PH_TAIL;

    always_comb begin
        state_nx = state;
        sh_ld    = state == LOAD;
        sh_en    = (state == ARMED && match) || (state == SHIFT && wrap);
        if (bus.line_start) state_nx = hit ? FETCH : IDLE;
        else if (state == FETCH) state_nx = LOAD;
        else if (state == LOAD) state_nx = ARMED;
        else if (state == ARMED && match) state_nx = SHIFT;
        else if (state == SHIFT && done) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rom_addr  <= '0;
            x_lat     <= '0;
            pcnt      <= '0;
            ph        <= '0;
            pix_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            pix_valid <= !bus.line_start && (state == SHIFT || (state == ARMED && match));
            if (bus.line_start && hit) begin
                x_lat    <= bus.sprite_x;
                rom_addr <= bus.base_addr + ADDR_W'(row);
            end
            if (state == ARMED) begin
                pcnt <= '0;
                ph   <= '0;
            end else if (state == SHIFT) begin
                ph <= wrap ? '0 : ph + 1'b1;
                if (wrap) pcnt <= pcnt + 1'b1;
            end
        end
    end

    assign bus.rom_addr  = rom_addr;
    assign bus.sh_data   = bus.rom_data;
    assign bus.sh_ld     = sh_ld;
    assign bus.sh_en     = sh_en;
    assign bus.pix_valid = pix_valid;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_sprite_line_ctrl.sv
// tb_sprite_line_ctrl: directed scanline scenarios; a negedge monitor scores strobes against queued expectations
module tb_sprite_line_ctrl;
    localparam int H_TOT = 1300;
    localparam int LS_H  = 1200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    int          en_q[$];
    int          pv_q[$];
    int          ldh_q[$];
    logic [31:0] ldd_q[$];

    sprite_line_if #(.ADDR_W(9)) bus();

    sprite_line_ctrl #(.SPRITE_H(16), .PIX_CLKS(2), .ADDR_W(9)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [8:0] a);
        return {7'h5A, a, 7'h21, ~a};
    endfunction

    always @(posedge clk) bus.rom_data <= romf(bus.rom_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s at hcount %0d: strobe seen, none expected", nm, bus.hcount);
    endtask

    // scoreboard monitor: every strobe must match the head of its expectation queue
    always @(negedge clk) begin
        if (bus.sh_ld && bus.sh_en) flag("ld_en_overlap");
        if (bus.sh_ld) begin
            if (ldh_q.size() == 0) flag("sh_ld_unexpected");
            else begin
                chk("sh_ld_hcount", 32'(bus.hcount), ldh_q.pop_front());
                chk("sh_data", bus.sh_data, ldd_q.pop_front());
            end
        end
        if (bus.sh_en) begin
            if (en_q.size() == 0) flag("sh_en_unexpected");
            else chk("sh_en_hcount", 32'(bus.hcount), en_q.pop_front());
        end
        if (bus.pix_valid) begin
            if (pv_q.size() == 0) flag("pix_valid_unexpected");
            else chk("pix_valid_hcount", 32'(bus.hcount), pv_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.hcount     = (bus.hcount == 11'(H_TOT - 1)) ? 11'd0 : bus.hcount + 11'd1;
        bus.line_start = 1'b0;
    endtask

    task automatic wait_h(input int h);
        while (bus.hcount != 11'(h)) tick();
    endtask

    task automatic ls(input logic [9:0] vc);
        bus.vcount     = vc;
        bus.line_start = 1'b1;
    endtask

    // expectations for sprite_x = 200 at PIX_CLKS = 2: sh_en from hcount 400, pix_valid from 401
    task automatic exp_row(input logic [8:0] a, input int ld_h, input int n_en, input int n_pv);
        ldh_q.push_back(ld_h);
        ldd_q.push_back(romf(a));
        for (int k = 0; k < n_en; k++) en_q.push_back(400 + 2 * k);
        for (int k = 0; k < n_pv; k++) pv_q.push_back(401 + k);
    endtask

    task automatic drain_chk(input string nm);
        chk({nm, "_ld_left"}, 32'(ldh_q.size()), 0);
        chk({nm, "_en_left"}, 32'(en_q.size()), 0);
        chk({nm, "_pv_left"}, 32'(pv_q.size()), 0);
        chk({nm, "_busy_end"}, 32'(bus.busy), 0);
    endtask

    task automatic next_line_440();
        wait_h(H_TOT - 1);
        wait_h(440);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hcount     = 11'd0;
        bus.vcount     = 10'd0;
        bus.line_start = 1'b0;
        bus.visible    = 1'b1;
        bus.sprite_x   = 10'd200;
        bus.sprite_y   = 10'd100;
        bus.base_addr  = 9'h040;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_sh_ld", 32'(bus.sh_ld), 0);
        chk("rst_sh_en", 32'(bus.sh_en), 0);
        chk("rst_pix_valid", 32'(bus.pix_valid), 0);
        reset = 1'b0;

        wait_h(LS_H);
        ls(10'd105);
        exp_row(9'h045, LS_H + 2, 16, 32);
        tick();
        chk("basic_rom_addr", 32'(bus.rom_addr), 32'h045);
        chk("basic_busy", 32'(bus.busy), 1);
        next_line_440();
        drain_chk("basic");

        wait_h(LS_H);
        ls(10'd99);
        tick();
        chk("v99_busy", 32'(bus.busy), 0);
        chk("v99_rom_addr", 32'(bus.rom_addr), 32'h045);
        tick();
        chk("v99_busy2", 32'(bus.busy), 0);

        wait_h(LS_H);
        ls(10'd116);
        tick();
        chk("v116_busy", 32'(bus.busy), 0);
        chk("v116_rom_addr", 32'(bus.rom_addr), 32'h045);

        wait_h(LS_H);
        ls(10'd115);
        exp_row(9'h04F, LS_H + 2, 16, 32);
        tick();
        chk("v115_rom_addr", 32'(bus.rom_addr), 32'h04F);
        next_line_440();
        drain_chk("v115");

        bus.visible = 1'b0;
        wait_h(LS_H);
        ls(10'd105);
        tick();
        chk("hidden_busy", 32'(bus.busy), 0);
        chk("hidden_rom_addr", 32'(bus.rom_addr), 32'h04F);
        tick();
        chk("hidden_busy2", 32'(bus.busy), 0);
        bus.visible = 1'b1;

        // abort at pixel 5 (hcount 410) with the next line, then move sprite_x while ARMED
        wait_h(LS_H);
        ls(10'd105);
        exp_row(9'h045, LS_H + 2, 6, 10);
        wait_h(H_TOT - 1);
        wait_h(410);
        ls(10'd106);
        exp_row(9'h046, 412, 16, 32);
        tick();
        chk("restart_rom_addr", 32'(bus.rom_addr), 32'h046);
        chk("restart_sh_en_off", 32'(bus.sh_en), 0);
        chk("restart_pix_valid_off", 32'(bus.pix_valid), 0);
        wait_h(420);
        bus.sprite_x = 10'd50;
        next_line_440();
        drain_chk("restart");
        bus.sprite_x = 10'd200;

        // x = 700 needs hcount 1400, which this line length never reaches
        bus.sprite_x = 10'd700;
        wait_h(LS_H);
        ls(10'd105);
        ldh_q.push_back(LS_H + 2);
        ldd_q.push_back(romf(9'h045));
        tick();
        wait_h(H_TOT - 1);
        wait_h(LS_H);
        chk("missed_still_armed", 32'(bus.busy), 1);
        bus.sprite_x = 10'd200;
        ls(10'd105);
        exp_row(9'h045, LS_H + 2, 16, 32);
        tick();
        chk("missed_refetch_addr", 32'(bus.rom_addr), 32'h045);
        next_line_440();
        drain_chk("missed");

        wait_h(LS_H);
        ls(10'd107);
        exp_row(9'h047, LS_H + 2, 3, 5);
        wait_h(H_TOT - 1);
        wait_h(406);
        reset = 1'b1;
        #1;
        chk("arst_sh_en", 32'(bus.sh_en), 0);
        chk("arst_pix_valid", 32'(bus.pix_valid), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_rom_addr", 32'(bus.rom_addr), 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        drain_chk("arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
